// File: rtl/am2910_pkg.sv
// rtl/am2910_pkg.sv - Am2910 opcodes and stack sizing.
// Stack depth is 9 when AM2910_DEEP_STACK_EN is defined, otherwise 5.
package am2910_pkg;

  typedef enum logic [3:0] {
    OP_JZ   = 4'd0,
    OP_CJS  = 4'd1,
    OP_JMAP = 4'd2,
    OP_CJP  = 4'd3,
    OP_PUSH = 4'd4,
    OP_JSRP = 4'd5,
    OP_CJV  = 4'd6,
    OP_JRP  = 4'd7,
    OP_RFCT = 4'd8,
    OP_RPCT = 4'd9,
    OP_CRTN = 4'd10,
    OP_CJPP = 4'd11,
    OP_LDCT = 4'd12,
    OP_LOOP = 4'd13,
    OP_CONT = 4'd14,
    OP_TWB  = 4'd15
  } am2910_op_e;

`ifdef AM2910_DEEP_STACK_EN
  localparam int STACK_DEPTH = 9;
`else
  localparam int STACK_DEPTH = 5;
`endif

  localparam int SP_W = $clog2(STACK_DEPTH + 1);

endpackage

// File: rtl/am2910_stack.sv
// rtl/am2910_stack.sv - LIFO for the sequencer: push at SP+1, overwrite TOS when full,
// pop when empty ignored, empty TOS reads 0. Depth from AM2910_DEEP_STACK_EN via the package.
module am2910_stack
  import am2910_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic        pop,
  input  logic        clear,
  input  logic [11:0] din,
  output logic [11:0] tos,
  output logic        full,
  output logic        empty
);

  // r_sp counts words held; entry r_sp-1 is the top of stack.
  logic [SP_W-1:0] r_sp;
  logic [11:0]     r_mem [STACK_DEPTH];

  assign empty = (r_sp == '0);
  assign full  = (r_sp == SP_W'(STACK_DEPTH));
  assign tos   = empty ? 12'h000 : r_mem[r_sp - 1'b1];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sp <= '0;
      for (int i = 0; i < STACK_DEPTH; i++) r_mem[i] <= 12'h000;
    end else if (clear) begin
      r_sp <= '0;
    end else if (push) begin
      if (full) begin
        r_mem[r_sp - 1'b1] <= din;
      end else begin
        r_mem[r_sp] <= din;
        r_sp        <= r_sp + 1'b1;
      end
    end else if (pop && !empty) begin
      r_sp <= r_sp - 1'b1;
    end
  end

endmodule

// File: rtl/am2910.sv
// rtl/am2910.sv - Am2910-compatible 12-bit microprogram sequencer (decode, uPC, R, Y mux).
// Stack depth selected by AM2910_DEEP_STACK_EN (9 when defined, 5 otherwise).
module am2910
  import am2910_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  I,
  input  logic [11:0] D,
  input  logic        nCC,
  input  logic        nCCEN,
  input  logic        CI,
  input  logic        nRLD,
  output logic [11:0] Y,
  output logic        nFULL,
  output logic        nPL,
  output logic        nMAP,
  output logic        nVECT
);

  logic [11:0] r_upc;
  logic [11:0] r_r;

  logic        w_pass;
  logic        w_r0;
  logic [11:0] w_y;
  logic        w_push;
  logic        w_pop;
  logic        w_clear;
  logic        w_load;
  logic        w_dec;
  logic [11:0] w_tos;
  logic        w_full;
  logic        w_empty;

  assign w_pass = nCCEN | ~nCC;
  assign w_r0   = (r_r == 12'h000);

  always_comb begin
    w_y     = r_upc;
    w_push  = 1'b0;
    w_pop   = 1'b0;
    w_clear = 1'b0;
    w_load  = 1'b0;
    w_dec   = 1'b0;
    case (am2910_op_e'(I))
      OP_JZ:   begin w_y = 12'h000; w_clear = 1'b1; end
      OP_CJS:  if (w_pass) begin w_y = D; w_push = 1'b1; end
      OP_JMAP: w_y = D;
      OP_CJP:  if (w_pass) w_y = D;
      OP_PUSH: begin w_push = 1'b1; w_load = w_pass; end
      OP_JSRP: begin w_push = 1'b1; w_y = w_pass ? D : r_r; end
      OP_CJV:  if (w_pass) w_y = D;
      OP_JRP:  w_y = w_pass ? D : r_r;
      OP_RFCT: if (!w_r0) begin w_y = w_tos; w_dec = 1'b1; end
               else w_pop = 1'b1;
      OP_RPCT: if (!w_r0) begin w_y = D; w_dec = 1'b1; end
      OP_CRTN: if (w_pass) begin w_y = w_tos; w_pop = 1'b1; end
      OP_CJPP: if (w_pass) begin w_y = D; w_pop = 1'b1; end
      OP_LDCT: w_load = 1'b1;
      OP_LOOP: if (w_pass) w_pop = 1'b1;
               else w_y = w_tos;
      OP_CONT: w_y = r_upc;
      OP_TWB: begin
        // Three-way branch: pass exits via uPC; on fail, R0 selects D (exit) vs TOS (loop).
        if (w_pass) begin
          w_pop = 1'b1;
        end else if (!w_r0) begin
          w_y   = w_tos;
          w_dec = 1'b1;
        end else begin
          w_y   = D;
          w_pop = 1'b1;
        end
      end
      default: w_y = r_upc;
    endcase
  end

  assign Y     = reset ? 12'h000 : w_y;
  assign nMAP  = reset ? 1'b1 : (I != OP_JMAP);
  assign nVECT = reset ? 1'b1 : (I != OP_CJV);
  assign nPL   = reset ? 1'b0 : ((I == OP_JMAP) || (I == OP_CJV));
  assign nFULL = reset ? 1'b1 : ~w_full;

  am2910_stack u_stack (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop & ~w_empty),
    .clear (w_clear),
    .din   (r_upc),
    .tos   (w_tos),
    .full  (w_full),
    .empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_upc <= 12'h000;
      r_r   <= 12'h000;
    end else begin
      r_upc <= w_y + {11'b0, CI};
      // An external nRLD load wins over anything the instruction asks of R.
      if (!nRLD)       r_r <= D;
      else if (w_load) r_r <= D;
      else if (w_dec)  r_r <= r_r - 12'h001;
    end
  end

endmodule

// File: tb/tb_am2910.sv
// tb/tb_am2910.sv - Directed self-checking bench for am2910 (default 5-deep stack build).
module tb_am2910;
  import am2910_pkg::*;

  logic        clk;
  logic        reset;
  logic [3:0]  I;
  logic [11:0] D;
  logic        nCC;
  logic        nCCEN;
  logic        CI;
  logic        nRLD;
  logic [11:0] Y;
  logic        nFULL;
  logic        nPL;
  logic        nMAP;
  logic        nVECT;

  int checks;
  int errors;

  am2910 dut (
    .clk   (clk),
    .reset (reset),
    .I     (I),
    .D     (D),
    .nCC   (nCC),
    .nCCEN (nCCEN),
    .CI    (CI),
    .nRLD  (nRLD),
    .Y     (Y),
    .nFULL (nFULL),
    .nPL   (nPL),
    .nMAP  (nMAP),
    .nVECT (nVECT)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [11:0] d, input logic ncc);
    I   = op;
    D   = d;
    nCC = ncc;
    #2;
  endtask

  task automatic test_reset();
    reset = 1'b1; nCCEN = 1'b0; CI = 1'b1; nRLD = 1'b1;
    drive(OP_JMAP, 12'h2A5, 1'b1);
    tick(); tick();
    drive(OP_JMAP, 12'h2A5, 1'b1);
    checks++;
    if (Y !== 12'h000) begin errors++; $display("FAIL reset_y got %h exp 000", Y); end
    checks++;
    if ({nPL, nMAP, nVECT, nFULL} !== 4'b0111) begin
      errors++; $display("FAIL reset_enables got %b exp 0111", {nPL, nMAP, nVECT, nFULL});
    end
    checks++;
    if (dut.r_upc !== 12'h000 || dut.r_r !== 12'h000 || dut.u_stack.r_sp !== 0) begin
      errors++; $display("FAIL reset_state got upc %h r %h sp %0d exp 0", dut.r_upc, dut.r_r, dut.u_stack.r_sp);
    end
    reset = 1'b0;
  endtask

  task automatic test_cont();
    logic [11:0] exp_y;
    for (int k = 0; k < 3; k++) begin
      drive(OP_CONT, 12'h000, 1'b1);
      exp_y = 12'(k);
      checks++;
      if (Y !== exp_y) begin errors++; $display("FAIL cont_y%0d got %h exp %h", k, Y, exp_y); end
      checks++;
      if ({nPL, nMAP, nVECT} !== 3'b011) begin
        errors++; $display("FAIL cont_enables got %b exp 011", {nPL, nMAP, nVECT});
      end
      tick();
    end
  endtask

  task automatic test_subroutine();
    drive(OP_CJP, 12'h010, 1'b0);
    checks++;
    if (Y !== 12'h010) begin errors++; $display("FAIL cjp_y got %h exp 010", Y); end
    tick();
    drive(OP_CJS, 12'h100, 1'b0);
    checks++;
    if (Y !== 12'h100) begin errors++; $display("FAIL cjs_y got %h exp 100", Y); end
    tick();
    drive(OP_CRTN, 12'h3FF, 1'b0);
    checks++;
    if (Y !== 12'h011) begin errors++; $display("FAIL crtn_y got %h exp 011", Y); end
    tick();
    checks++;
    if (dut.u_stack.r_sp !== 0) begin errors++; $display("FAIL crtn_sp got %0d exp 0", dut.u_stack.r_sp); end
  endtask

  task automatic test_counter_loop();
    drive(OP_LDCT, 12'h003, 1'b1);
    checks++;
    if (Y !== 12'h012) begin errors++; $display("FAIL ldct_y got %h exp 012", Y); end
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(OP_RPCT, 12'h050, 1'b1);
      checks++;
      if (Y !== 12'h050) begin errors++; $display("FAIL rpct_loop%0d got %h exp 050", k, Y); end
      tick();
    end
    drive(OP_RPCT, 12'h050, 1'b1);
    checks++;
    if (Y !== 12'h051) begin errors++; $display("FAIL rpct_exit got %h exp 051", Y); end
    tick();
    checks++;
    if (dut.r_r !== 12'h000) begin errors++; $display("FAIL rpct_r0 got %h exp 000", dut.r_r); end
    // nRLD during RPCT: R takes D instead of decrementing
    drive(OP_LDCT, 12'h002, 1'b1);
    tick();
    nRLD = 1'b0;
    drive(OP_RPCT, 12'h050, 1'b1);
    checks++;
    if (Y !== 12'h050) begin errors++; $display("FAIL rpct_nrld_y got %h exp 050", Y); end
    tick();
    nRLD = 1'b1;
    checks++;
    if (dut.r_r !== 12'h050) begin errors++; $display("FAIL rpct_nrld_r got %h exp 050", dut.r_r); end
    drive(OP_RPCT, 12'h050, 1'b1);
    tick();
    checks++;
    if (dut.r_r !== 12'h04F) begin errors++; $display("FAIL rpct_dec_r got %h exp 04f", dut.r_r); end
  endtask

  task automatic test_stack_full();
    logic [11:0] pops [6];
    pops[0] = 12'h107; pops[1] = 12'h105; pops[2] = 12'h104;
    pops[3] = 12'h103; pops[4] = 12'h102; pops[5] = 12'h000;
    drive(OP_JMAP, 12'h101, 1'b1);
    tick();
    for (int k = 0; k < 6; k++) begin
      drive(OP_PUSH, 12'h0AA, 1'b1);
      checks++;
      if (Y !== 12'h102 + 12'(k)) begin
        errors++; $display("FAIL push%0d_y got %h exp %h", k, Y, 12'h102 + 12'(k));
      end
      tick();
      checks++;
      if (nFULL !== (k < 4)) begin errors++; $display("FAIL push%0d_nfull got %b exp %b", k, nFULL, k < 4); end
    end
    checks++;
    if (dut.u_stack.r_sp !== 5) begin errors++; $display("FAIL full_sp got %0d exp 5", dut.u_stack.r_sp); end
    for (int k = 0; k < 6; k++) begin
      drive(OP_CRTN, 12'h3FF, 1'b0);
      checks++;
      if (Y !== pops[k]) begin errors++; $display("FAIL pop%0d_y got %h exp %h", k, Y, pops[k]); end
      tick();
    end
    checks++;
    if (dut.u_stack.r_sp !== 0 || nFULL !== 1'b1) begin
      errors++; $display("FAIL empty_sp got sp %0d nfull %b exp 0 1", dut.u_stack.r_sp, nFULL);
    end
  endtask

  task automatic test_map_vector();
    drive(OP_JMAP, 12'h2A5, 1'b1);
    checks++;
    if (Y !== 12'h2A5 || {nPL, nMAP, nVECT} !== 3'b101) begin
      errors++; $display("FAIL jmap got y %h en %b exp 2a5 101", Y, {nPL, nMAP, nVECT});
    end
    tick();
    drive(OP_CJV, 12'h3C3, 1'b1);
    checks++;
    if (Y !== 12'h2A6 || {nPL, nMAP, nVECT} !== 3'b110) begin
      errors++; $display("FAIL cjv_fail got y %h en %b exp 2a6 110", Y, {nPL, nMAP, nVECT});
    end
    drive(OP_CJV, 12'h3C3, 1'b0);
    checks++;
    if (Y !== 12'h3C3) begin errors++; $display("FAIL cjv_pass got %h exp 3c3", Y); end
    tick();
  endtask

  task automatic test_wrap_and_jz();
    drive(OP_CJP, 12'hFFF, 1'b0);
    tick();
    drive(OP_CONT, 12'h000, 1'b1);
    checks++;
    if (Y !== 12'h000) begin errors++; $display("FAIL upc_wrap got %h exp 000", Y); end
    tick();
    drive(OP_PUSH, 12'h000, 1'b1);
    tick();
    drive(OP_JZ, 12'h777, 1'b1);
    checks++;
    if (Y !== 12'h000) begin errors++; $display("FAIL jz_y got %h exp 000", Y); end
    tick();
    checks++;
    if (dut.u_stack.r_sp !== 0) begin errors++; $display("FAIL jz_sp got %0d exp 0", dut.u_stack.r_sp); end
  endtask

  task automatic test_twb_reset();
    drive(OP_LDCT, 12'h005, 1'b1);
    checks++;
    if (Y !== 12'h001) begin errors++; $display("FAIL twb_ldct_y got %h exp 001", Y); end
    tick();
    drive(OP_PUSH, 12'h000, 1'b1);
    tick();
    drive(OP_PUSH, 12'h000, 1'b1);
    tick();
    drive(OP_TWB, 12'h0AA, 1'b1);
    checks++;
    if (Y !== 12'h003) begin errors++; $display("FAIL twb_y got %h exp 003", Y); end
    reset = 1'b1;
    #1;
    checks++;
    if (Y !== 12'h000 || nPL !== 1'b0) begin errors++; $display("FAIL twb_reset_y got %h %b exp 000 0", Y, nPL); end
    tick();
    checks++;
    if (dut.r_upc !== 12'h000 || dut.r_r !== 12'h000 || dut.u_stack.r_sp !== 0) begin
      errors++; $display("FAIL twb_reset_state got upc %h r %h sp %0d exp 0", dut.r_upc, dut.r_r, dut.u_stack.r_sp);
    end
    reset = 1'b0;
    CI = 1'b0;
    drive(OP_CONT, 12'h000, 1'b1);
    checks++;
    if (Y !== 12'h000 || nFULL !== 1'b1) begin errors++; $display("FAIL post_reset got y %h nfull %b exp 000 1", Y, nFULL); end
    drive(OP_CRTN, 12'h000, 1'b0);
    checks++;
    if (Y !== 12'h000) begin errors++; $display("FAIL post_reset_tos got %h exp 000", Y); end
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_cont();
    test_subroutine();
    test_counter_loop();
    test_stack_full();
    test_map_vector();
    test_wrap_and_jz();
    test_twb_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
